xaui_link_sequencer: RTL and testbench
======================================

// Module: xaui_link_sequencer
// PURPOSE
//  Per-port bring-up and supervision FSM for up to NUM_PORTS XAUI/GTX ports; sits between the
//  MGT infrastructure wrapper and the XAUI cores. Sequences PMA-side user resets, comma
//  alignment and channel sync. Declares link_up, detects link loss and retries automatically,
//  with bounded retries and saturating health counters per port.
// PARAMETERS
//  NUM_PORTS      8        number of XAUI ports (1..8)
//  LANES          4        lanes per port (fixed 4 for XAUI; kept generic)
//  ENABLE_MASK    8'hFF    per-port enable; disabled ports held in S_RST forever
//  RST_CYCLES     64       cycles tx/rx reset held in S_RST
//  LOCK_TIMEOUT   65535    max cycles in S_LOCK before retry
//  ALIGN_TIMEOUT  65535    max cycles in S_ALIGN before retry
//  STABLE_CYCLES  1024     consecutive all-lane syncok cycles needed to leave S_ALIGN
//  CSYNC_CYCLES   256      cycles enchansync held in S_CSYNC
//  RETRY_LIMIT    16       consecutive failed attempts before S_FAIL; 0 = unlimited
// PORTS
//  xaui_clk            in   1              sole clock (GTX TXOUTCLK via BUFG)
//  mgt_reset           in   1              synchronous, active-high reset
//  port_restart        in   NUM_PORTS      1-cycle pulse: force port to S_RST, clear retry count
//  mgt_rxlock          in   NUM_PORTS*4    per-lane RX PLL lock
//  mgt_rxelecidle      in   NUM_PORTS*4    per-lane electrical idle
//  mgt_rxsyncok        in   NUM_PORTS*4    per-lane 8b10b sync OK
//  mgt_rxcodevalid     in   NUM_PORTS*8    per-byte code valid (2 per lane)
//  mgt_rxbufferr       in   NUM_PORTS*4    per-lane elastic buffer error
//  mgt_tx_rst          out  NUM_PORTS      TX user reset to infrastructure
//  mgt_rx_rst          out  NUM_PORTS      RX user/buffer reset to infrastructure
//  mgt_rxencommaalign  out  NUM_PORTS*4    comma-align enable, all 4 lanes driven together
//  mgt_rxenchansync    out  NUM_PORTS      channel-bond enable
//  link_up             out  NUM_PORTS      port in S_UP
//  port_state          out  NUM_PORTS*3    encoded FSM state per port
//  retry_count         out  NUM_PORTS*8    consecutive failed attempts, saturates 255
//  link_drop_count     out  NUM_PORTS*16   S_UP->S_RST transitions, saturates 16'hFFFF
// BEHAVIOUR
//  - Reset (mgt_reset=1, registered on xaui_clk): all ports S_RST, cycle counter 0,
//    tx_rst=rx_rst=1, encommaalign=0, enchansync=0, link_up=0, all counters 0.
//  - States (3b): S_RST=0, S_LOCK=1, S_ALIGN=2, S_CSYNC=3, S_UP=4, S_FAIL=5.
//  - S_RST: tx_rst=rx_rst=1; after RST_CYCLES cycles -> S_LOCK (if enabled).
//  - S_LOCK: resets 0; all 4 rxlock=1 and all rxelecidle=0 -> S_ALIGN;
//    counter reaches LOCK_TIMEOUT -> retry.
//  - S_ALIGN: encommaalign=4'hF; stable counter increments while all syncok=1, clears on any 0.
//    Reaching STABLE_CYCLES -> S_CSYNC; ALIGN_TIMEOUT -> retry.
//  - S_CSYNC: enchansync=1, encommaalign=0 for CSYNC_CYCLES. At end:
//    all 8 codevalid=1 and bufferr=0 -> S_UP, retry_count cleared; else retry.
//  - S_UP: link_up=1 (registered, asserted 1st cycle in S_UP). Any syncok=0, bufferr=1 or
//    elecidle=1 on any lane -> S_RST, link_drop_count++. Not counted as a retry failure.
//  - Retry: retry_count++ (saturating), -> S_RST.
//    If RETRY_LIMIT!=0 and new retry_count==RETRY_LIMIT -> S_FAIL.
//  - S_FAIL: tx_rst=rx_rst=1, link_up=0; exits only on mgt_reset or port_restart.
//  - Priority: mgt_reset > port_restart > success condition > timeout/fault.
//    Success and timeout in the same cycle -> success.
//  - Counter width $clog2(max timeout)+1; counter zeroed on every state entry.
//  - Ports are independent; port index p uses lane bits [p*4+:4], byte bits [p*8+:8].
//  - Ports >= NUM_PORTS do not exist; ENABLE_MASK bits >= NUM_PORTS ignored.
// STRUCTURE
//  - Package xaui_link_pkg: state localparams, STATE_W=3, CNT_W function.
//  - Sub-module xaui_link_fsm: one port FSM + counters, generated NUM_PORTS times.
//  - Top: slicing and concatenation only.
// TESTING
//  1 Reset, all lanes locked and syncok, codevalid=8'hFF
//    -> link_up rises at 64+1+1024+256+O(1) cycles; retry_count=0.
//  2 rxlock lane 2 held 0, LOCK_TIMEOUT=100, RETRY_LIMIT=3
//    -> three S_RST/S_LOCK cycles, then S_FAIL (state=5), retry_count=3, tx_rst=1.
//  3 Port in S_UP, drop syncok lane 1 for 1 cycle
//    -> next cycle S_RST, link_up=0, link_drop_count=1, relinks automatically.
//  4 In S_ALIGN, syncok glitches every 500 cycles (STABLE_CYCLES=1024)
//    -> never reaches S_CSYNC; ALIGN_TIMEOUT retry fires.
//  5 Port in S_FAIL, port_restart pulse -> S_RST, retry_count=0, full bring-up succeeds.
//  6 ENABLE_MASK=8'h0F -> ports 4..7 hold tx_rst=rx_rst=1, link_up=0; ports 0..3 unaffected.

Source files
------------

// File: rtl/xaui_link_pkg.sv
// Shared types and sizing helpers for the XAUI link bring-up sequencer.
package xaui_link_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 8;
  localparam int DROP_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    S_RST   = 3'd0,
    S_LOCK  = 3'd1,
    S_ALIGN = 3'd2,
    S_CSYNC = 3'd3,
    S_UP    = 3'd4,
    S_FAIL  = 3'd5
  } state_e;

  // Width of a cycle counter able to reach the longest of the phase lengths,
  // with one spare bit so the terminal value is never the all-ones saturation value.
  function automatic int cnt_w(input int a, input int b, input int c,
                               input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/xaui_link_sequencer_if.sv
// Bundle of per-port MGT status inputs and sequencer control/status outputs.
interface xaui_link_sequencer_if
  import xaui_link_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int LANES     = 4
);
  logic [NUM_PORTS-1:0]         port_restart;
  logic [NUM_PORTS*LANES-1:0]   mgt_rxlock;
  logic [NUM_PORTS*LANES-1:0]   mgt_rxelecidle;
  logic [NUM_PORTS*LANES-1:0]   mgt_rxsyncok;
  logic [NUM_PORTS*LANES*2-1:0] mgt_rxcodevalid;
  logic [NUM_PORTS*LANES-1:0]   mgt_rxbufferr;
  logic [NUM_PORTS-1:0]         mgt_tx_rst;
  logic [NUM_PORTS-1:0]         mgt_rx_rst;
  logic [NUM_PORTS*LANES-1:0]   mgt_rxencommaalign;
  logic [NUM_PORTS-1:0]         mgt_rxenchansync;
  logic [NUM_PORTS-1:0]         link_up;
  logic [NUM_PORTS*STATE_W-1:0] port_state;
  logic [NUM_PORTS*RETRY_W-1:0] retry_count;
  logic [NUM_PORTS*DROP_W-1:0]  link_drop_count;

  // Environment side: MGT infrastructure and management.
  modport master (
    output port_restart, mgt_rxlock, mgt_rxelecidle, mgt_rxsyncok,
           mgt_rxcodevalid, mgt_rxbufferr,
    input  mgt_tx_rst, mgt_rx_rst, mgt_rxencommaalign, mgt_rxenchansync,
           link_up, port_state, retry_count, link_drop_count
  );

  // Sequencer side.
  modport slave (
    input  port_restart, mgt_rxlock, mgt_rxelecidle, mgt_rxsyncok,
           mgt_rxcodevalid, mgt_rxbufferr,
    output mgt_tx_rst, mgt_rx_rst, mgt_rxencommaalign, mgt_rxenchansync,
           link_up, port_state, retry_count, link_drop_count
  );
endinterface

// File: rtl/xaui_link_fsm.sv
// One XAUI port: reset -> PLL lock -> comma align -> channel sync -> link up,
// with timeouts, bounded retries and saturating health counters.
module xaui_link_fsm
  import xaui_link_pkg::*;
#(
  parameter int LANES         = 4,
  parameter bit PORT_EN       = 1'b1,
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int ALIGN_TIMEOUT = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int CSYNC_CYCLES  = 256,
  parameter int RETRY_LIMIT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [LANES-1:0]     rxlock,
  input  logic [LANES-1:0]     rxelecidle,
  input  logic [LANES-1:0]     rxsyncok,
  input  logic [2*LANES-1:0]   rxcodevalid,
  input  logic [LANES-1:0]     rxbufferr,
  output logic                 tx_rst,
  output logic                 rx_rst,
  output logic [LANES-1:0]     encommaalign,
  output logic                 enchansync,
  output logic                 link_up,
  output logic [STATE_W-1:0]   state,
  output logic [RETRY_W-1:0]   retry_count,
  output logic [DROP_W-1:0]    drop_count
);
  localparam int CW = cnt_w(RST_CYCLES, LOCK_TIMEOUT, ALIGN_TIMEOUT,
                            STABLE_CYCLES, CSYNC_CYCLES);
  localparam logic [CW-1:0] RST_END    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_END   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ALIGN_END  = CW'(ALIGN_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_END = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CSYNC_END  = CW'(CSYNC_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        stable_q, stable_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [DROP_W-1:0]    drops_q, drops_d;
  logic                 mgt_rst_q, mgt_rst_d;
  logic                 comma_q, comma_d;
  logic                 chansync_q, chansync_d;
  logic                 link_up_q, link_up_d;
  logic                 attempt_fail;

  // Next-state, counters and registered-output decode for this port.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    stable_d     = '0;
    retry_d      = retry_q;
    drops_d      = drops_q;
    attempt_fail = 1'b0;

    case (state_q)
      S_RST: begin
        if (!PORT_EN) cnt_d = '0;
        else if (cnt_q == RST_END) state_d = S_LOCK;
      end
      S_LOCK: begin
        if ((&rxlock) && !(|rxelecidle)) state_d = S_ALIGN;
        else if (cnt_q == LOCK_END) attempt_fail = 1'b1;
      end
      S_ALIGN: begin
        stable_d = (&rxsyncok) ? stable_q + 1'b1 : '0;
        if ((&rxsyncok) && (stable_q == STABLE_END)) state_d = S_CSYNC;
        else if (cnt_q == ALIGN_END) attempt_fail = 1'b1;
      end
      S_CSYNC: begin
        if (cnt_q == CSYNC_END) begin
          if ((&rxcodevalid) && !(|rxbufferr)) begin
            state_d = S_UP;
            retry_d = '0;
          end else begin
            attempt_fail = 1'b1;
          end
        end
      end
      S_UP: begin
        // A lost link is a drop, not a failed attempt.
        if (!(&rxsyncok) || (|rxbufferr) || (|rxelecidle)) begin
          state_d = S_RST;
          drops_d = (drops_q == '1) ? drops_q : drops_q + 1'b1;
        end
      end
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_RST;
    endcase

    if (attempt_fail) begin
      retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
      state_d = ((RETRY_LIMIT != 0) && (int'(retry_d) == RETRY_LIMIT)) ? S_FAIL : S_RST;
    end

    if (restart) begin
      state_d = S_RST;
      retry_d = '0;
    end

    if (restart || (state_d != state_q)) begin
      cnt_d    = '0;
      stable_d = '0;
    end

    mgt_rst_d  = (state_d == S_RST) || (state_d == S_FAIL);
    comma_d    = (state_d == S_ALIGN);
    chansync_d = (state_d == S_CSYNC);
    link_up_d  = (state_d == S_UP);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      cnt_q      <= '0;
      stable_q   <= '0;
      retry_q    <= '0;
      drops_q    <= '0;
      mgt_rst_q  <= 1'b1;
      comma_q    <= 1'b0;
      chansync_q <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      retry_q    <= retry_d;
      drops_q    <= drops_d;
      mgt_rst_q  <= mgt_rst_d;
      comma_q    <= comma_d;
      chansync_q <= chansync_d;
      link_up_q  <= link_up_d;
    end
  end

  assign tx_rst       = mgt_rst_q;
  assign rx_rst       = mgt_rst_q;
  assign encommaalign = {LANES{comma_q}};
  assign enchansync   = chansync_q;
  assign link_up      = link_up_q;
  assign state        = state_q;
  assign retry_count  = retry_q;
  assign drop_count   = drops_q;

endmodule

// File: rtl/xaui_link_sequencer.sv
// Multi-port XAUI bring-up sequencer: one independent FSM per port, top only slices buses.
module xaui_link_sequencer
  import xaui_link_pkg::*;
#(
  parameter int         NUM_PORTS     = 8,
  parameter int         LANES         = 4,
  parameter logic [7:0] ENABLE_MASK   = 8'hFF,
  parameter int         RST_CYCLES    = 64,
  parameter int         LOCK_TIMEOUT  = 65535,
  parameter int         ALIGN_TIMEOUT = 65535,
  parameter int         STABLE_CYCLES = 1024,
  parameter int         CSYNC_CYCLES  = 256,
  parameter int         RETRY_LIMIT   = 16
) (
  input  logic                  xaui_clk,
  input  logic                  mgt_reset,
  xaui_link_sequencer_if.slave  bus
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    xaui_link_fsm #(
      .LANES         (LANES),
      .PORT_EN       (ENABLE_MASK[p]),
      .RST_CYCLES    (RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .ALIGN_TIMEOUT (ALIGN_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .CSYNC_CYCLES  (CSYNC_CYCLES),
      .RETRY_LIMIT   (RETRY_LIMIT)
    ) u_fsm (
      .clk          (xaui_clk),
      .rst          (mgt_reset),
      .restart      (bus.port_restart[p]),
      .rxlock       (bus.mgt_rxlock[p*LANES +: LANES]),
      .rxelecidle   (bus.mgt_rxelecidle[p*LANES +: LANES]),
      .rxsyncok     (bus.mgt_rxsyncok[p*LANES +: LANES]),
      .rxcodevalid  (bus.mgt_rxcodevalid[p*2*LANES +: 2*LANES]),
      .rxbufferr    (bus.mgt_rxbufferr[p*LANES +: LANES]),
      .tx_rst       (bus.mgt_tx_rst[p]),
      .rx_rst       (bus.mgt_rx_rst[p]),
      .encommaalign (bus.mgt_rxencommaalign[p*LANES +: LANES]),
      .enchansync   (bus.mgt_rxenchansync[p]),
      .link_up      (bus.link_up[p]),
      .state        (bus.port_state[p*STATE_W +: STATE_W]),
      .retry_count  (bus.retry_count[p*RETRY_W +: RETRY_W]),
      .drop_count   (bus.link_drop_count[p*DROP_W +: DROP_W])
    );
  end

endmodule

// File: tb/tb_xaui_link_sequencer.sv
// Bench for xaui_link_sequencer: eight ports run different bring-up scenarios at once.
module tb_xaui_link_sequencer;
  import xaui_link_pkg::*;

  localparam int NP = 8;
  localparam int LN = 4;
  localparam int LAST_CYC = 6400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xaui_link_sequencer_if #(.NUM_PORTS(NP), .LANES(LN)) bus ();

  xaui_link_sequencer #(
    .NUM_PORTS(NP), .LANES(LN), .ENABLE_MASK(8'h0F), .RST_CYCLES(64),
    .LOCK_TIMEOUT(100), .ALIGN_TIMEOUT(2000), .STABLE_CYCLES(1024),
    .CSYNC_CYCLES(256), .RETRY_LIMIT(3)
  ) dut (
    .xaui_clk (clk),
    .mgt_reset(rst),
    .bus      (bus)
  );

  typedef enum int {A_NONE, A_RESTART_FIXLOCK, A_RESTART_BADCV, A_GLITCH_SYNC1} act_e;

  typedef struct {
    int          at_cyc;
    int          port;
    act_e        act;
    int          chk_cyc;
    logic [2:0]  st;
    logic [7:0]  retry;
    logic [15:0] drops;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  logic [LN-1:0]   lock[NP];
  logic [LN-1:0]   idle[NP];
  logic [LN-1:0]   sync[NP];
  logic [LN-1:0]   berr[NP];
  logic [2*LN-1:0] cv[NP];
  logic [NP-1:0]   restart;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lu0_rise = 0;
  int dis_bad = 0;

  function automatic vec_t mk(input int a, input int p, input act_e ac, input int c,
                              input logic [2:0] st, input logic [7:0] r,
                              input logic [15:0] d);
    vec_t v;
    v.at_cyc = a; v.port = p; v.act = ac; v.chk_cyc = c;
    v.st = st; v.retry = r; v.drops = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.mgt_rxlock[p*LN +: LN]          = lock[p];
      bus.mgt_rxelecidle[p*LN +: LN]      = idle[p];
      bus.mgt_rxsyncok[p*LN +: LN]        = sync[p];
      bus.mgt_rxbufferr[p*LN +: LN]       = berr[p];
      bus.mgt_rxcodevalid[p*2*LN +: 2*LN] = cv[p];
    end
    bus.port_restart = restart;
  endtask

  // Compare one port against the outputs each state is defined to drive.
  task automatic check_port(input vec_t v);
    int p;
    string t;
    logic trst, lu, cs;
    logic [LN-1:0] cm;
    p = v.port;
    t = $sformatf("p%0d@%0d", p, cyc);
    trst = (v.st == 3'd0) || (v.st == 3'd5);
    lu   = (v.st == 3'd4);
    cs   = (v.st == 3'd3);
    cm   = (v.st == 3'd2) ? 4'hF : 4'h0;
    chk({t, " state"},    32'(bus.port_state[p*3 +: 3]),        32'(v.st));
    chk({t, " link_up"},  32'(bus.link_up[p]),                  32'(lu));
    chk({t, " tx_rst"},   32'(bus.mgt_tx_rst[p]),               32'(trst));
    chk({t, " rx_rst"},   32'(bus.mgt_rx_rst[p]),               32'(trst));
    chk({t, " comma"},    32'(bus.mgt_rxencommaalign[p*LN +: LN]), 32'(cm));
    chk({t, " chansync"}, 32'(bus.mgt_rxenchansync[p]),         32'(cs));
    chk({t, " retry"},    32'(bus.retry_count[p*8 +: 8]),       32'(v.retry));
    chk({t, " drops"},    32'(bus.link_drop_count[p*16 +: 16]), 32'(v.drops));
  endtask

  initial begin
    // Port 0: clean bring-up, later one-cycle syncok drop on lane 1 and relink.
    tbl.push_back(mk(  30, 0, A_NONE,           30, 3'd0, 8'd0, 16'd0));
    tbl.push_back(mk( 100, 0, A_NONE,          100, 3'd2, 8'd0, 16'd0));
    tbl.push_back(mk(1200, 0, A_NONE,         1200, 3'd3, 8'd0, 16'd0));
    tbl.push_back(mk(1400, 0, A_NONE,         1400, 3'd4, 8'd0, 16'd0));
    tbl.push_back(mk(1600, 0, A_GLITCH_SYNC1, 1601, 3'd0, 8'd0, 16'd1));
    tbl.push_back(mk(2940, 0, A_NONE,         2940, 3'd3, 8'd0, 16'd1));
    tbl.push_back(mk(3000, 0, A_NONE,         3000, 3'd4, 8'd0, 16'd1));
    tbl.push_back(mk(6300, 0, A_NONE,         6300, 3'd4, 8'd0, 16'd1));
    // Port 1: lane 2 never locks -> three lock timeouts -> S_FAIL; restart recovers.
    tbl.push_back(mk( 200, 1, A_NONE,            200, 3'd0, 8'd1, 16'd0));
    tbl.push_back(mk( 300, 1, A_NONE,            300, 3'd1, 8'd1, 16'd0));
    tbl.push_back(mk( 600, 1, A_NONE,            600, 3'd5, 8'd3, 16'd0));
    tbl.push_back(mk(1000, 1, A_RESTART_FIXLOCK, 1000, 3'd5, 8'd3, 16'd0));
    tbl.push_back(mk(1002, 1, A_NONE,           1002, 3'd0, 8'd0, 16'd0));
    tbl.push_back(mk(2000, 1, A_NONE,           2000, 3'd2, 8'd0, 16'd0));
    tbl.push_back(mk(2400, 1, A_NONE,           2400, 3'd4, 8'd0, 16'd0));
    tbl.push_back(mk(6300, 1, A_NONE,           6300, 3'd4, 8'd0, 16'd0));
    // Port 2: syncok glitch every 500 cycles -> align timeouts, eventually S_FAIL.
    tbl.push_back(mk(1500, 2, A_NONE, 1500, 3'd2, 8'd0, 16'd0));
    tbl.push_back(mk(2060, 2, A_NONE, 2060, 3'd2, 8'd0, 16'd0));
    tbl.push_back(mk(2070, 2, A_NONE, 2070, 3'd0, 8'd1, 16'd0));
    tbl.push_back(mk(6300, 2, A_NONE, 6300, 3'd5, 8'd3, 16'd0));
    // Port 3: links, then restarted with one bad code-valid byte -> channel-sync retries.
    tbl.push_back(mk(1400, 3, A_NONE,          1400, 3'd4, 8'd0, 16'd0));
    tbl.push_back(mk(1500, 3, A_RESTART_BADCV, 1500, 3'd4, 8'd0, 16'd0));
    tbl.push_back(mk(1502, 3, A_NONE,          1502, 3'd0, 8'd0, 16'd0));
    tbl.push_back(mk(2700, 3, A_NONE,          2700, 3'd3, 8'd0, 16'd0));
    tbl.push_back(mk(2860, 3, A_NONE,          2860, 3'd0, 8'd1, 16'd0));
    tbl.push_back(mk(6300, 3, A_NONE,          6300, 3'd5, 8'd3, 16'd0));
    // Disabled ports stay in reset.
    tbl.push_back(mk(1400, 5, A_NONE, 1400, 3'd0, 8'd0, 16'd0));
    tbl.push_back(mk(6300, 7, A_NONE, 6300, 3'd0, 8'd0, 16'd0));

    for (int p = 0; p < NP; p++) begin
      lock[p] = 4'hF; idle[p] = 4'h0; sync[p] = 4'hF; berr[p] = 4'h0; cv[p] = 8'hFF;
    end
    lock[1] = 4'b1011;
    restart = '0;
    rst = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("reset state",    32'(bus.port_state),         32'd0);
    chk("reset tx_rst",   32'(bus.mgt_tx_rst),         32'hFF);
    chk("reset rx_rst",   32'(bus.mgt_rx_rst),         32'hFF);
    chk("reset comma",    bus.mgt_rxencommaalign,      32'd0);
    chk("reset chansync", 32'(bus.mgt_rxenchansync),   32'd0);
    chk("reset link_up",  32'(bus.link_up),            32'd0);
    chk("reset retry",    bus.retry_count[31:0],       32'd0);
    chk("reset drops",    bus.link_drop_count[31:0],   32'd0);
    rst = 1'b0;

    for (int k = 1; k <= LAST_CYC; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      for (int i = 0; i < tbl.size(); i++)
        if (tbl[i].at_cyc == cyc) sb.push_back(tbl[i]);
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].chk_cyc == cyc) begin
          check_port(sb[i]);
          sb.delete(i);
        end
      if (lu0_rise == 0 && bus.link_up[0]) lu0_rise = cyc;
      if (bus.link_up[7:4] != 4'h0 || bus.mgt_tx_rst[7:4] != 4'hF ||
          bus.mgt_rx_rst[7:4] != 4'hF || bus.port_state[23:12] != 12'h0)
        dis_bad++;

      restart = '0;
      sync[0] = 4'hF;
      sync[2] = (((cyc + 1) % 500) == 0) ? 4'hE : 4'hF;
      for (int i = 0; i < tbl.size(); i++)
        if (tbl[i].at_cyc == cyc) begin
          case (tbl[i].act)
            A_RESTART_FIXLOCK: begin lock[tbl[i].port] = 4'hF; restart[tbl[i].port] = 1'b1; end
            A_RESTART_BADCV:   begin cv[tbl[i].port] = 8'hDF; restart[tbl[i].port] = 1'b1; end
            A_GLITCH_SYNC1:    sync[tbl[i].port] = 4'b1101;
            default: ;
          endcase
        end
      drive();
    end

    checks++;
    if (lu0_rise < 1340 || lu0_rise > 1350) begin
      errors++;
      $display("FAIL link_up rise cycle got %0d expected 1340..1350", lu0_rise);
    end
    chk("disabled ports bad cycles", 32'(dis_bad), 32'd0);
    chk("scoreboard leftovers", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
